// File: rtl/puf_eval_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : puf_eval_ctrl
//  Description : Sequencer that evaluates a shared one-bit ring-oscillator
//                PUF over RESP_BITS consecutive challenges and assembles the
//                results into one response word. For every bit it clears
//                the PUF counters, enables the oscillators for a fixed
//                window, waits for the comparator to settle, then samples
//                the comparator output.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                req_valid/req_ready - request handshake
//                req_challenge[7:0]  - base challenge, captured on accept
//                resp_valid/ready    - response handshake
//                resp_data           - bit k = PUF(base + k mod 256)
//                busy                - high whenever not idle
//                puf_en, puf_reset   - PUF oscillator enable / counter clear
//                puf_challenge[7:0]  - challenge driven to the PUF
//                puf_out             - PUF comparator result
//  Revision    : 1.0 - initial release
// ============================================================================
module puf_eval_ctrl #(
    parameter int RESP_BITS     = 16,
    parameter int WIN_CYCLES    = 1024,
    parameter int SETTLE_CYCLES = 4,
    parameter int CLR_CYCLES    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [7:0]           req_challenge,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [RESP_BITS-1:0] resp_data,
    output logic                 busy,
    output logic                 puf_en,
    output logic                 puf_reset,
    output logic [7:0]           puf_challenge,
    input  logic                 puf_out
);

    localparam int IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    // One phase counter serves CLR, RUN and HOLD; it is sized for the
    // longest of the three so every phase fits.
    localparam int MAX_PHASE =
        (WIN_CYCLES >= CLR_CYCLES && WIN_CYCLES >= SETTLE_CYCLES) ? WIN_CYCLES :
        (CLR_CYCLES >= SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W = $clog2(MAX_PHASE + 1);

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(RESP_BITS - 1);
    localparam logic [CNT_W-1:0] CLR_LAST    = CNT_W'(CLR_CYCLES - 1);
    localparam logic [CNT_W-1:0] WIN_LAST    = CNT_W'(WIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLR    = 3'd1,
        S_RUN    = 3'd2,
        S_HOLD   = 3'd3,
        S_SAMPLE = 3'd4,
        S_OUT    = 3'd5
    } state_t;

    state_t                 state_q,         state_d;
    logic [CNT_W-1:0]       cnt_q,           cnt_d;
    logic [IDX_W-1:0]       bit_idx_q,       bit_idx_d;
    logic [7:0]             base_q,          base_d;
    logic [RESP_BITS-1:0]   resp_data_q,     resp_data_d;
    logic                   req_ready_q,     req_ready_d;
    logic                   resp_valid_q,    resp_valid_d;
    logic                   busy_q,          busy_d;
    logic                   puf_en_q,        puf_en_d;
    logic                   puf_reset_q,     puf_reset_d;
    logic [7:0]             puf_challenge_q, puf_challenge_d;

    // Next-state and datapath
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        base_d      = base_q;
        resp_data_d = resp_data_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    base_d      = req_challenge;
                    bit_idx_d   = '0;
                    resp_data_d = '0;
                    cnt_d       = '0;
                    state_d     = S_CLR;
                end
            end
            S_CLR: begin
                if (cnt_q == CLR_LAST) begin
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (cnt_q == WIN_LAST) begin
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SAMPLE: begin
                resp_data_d[bit_idx_q] = puf_out;
                if (bit_idx_q == LAST_IDX) begin
                    state_d = S_OUT;
                end else begin
                    bit_idx_d = bit_idx_q + IDX_W'(1);
                    cnt_d     = '0;
                    state_d   = S_CLR;
                end
            end
            S_OUT: begin
                if (resp_ready && resp_valid_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered pins line
    // up with the state they belong to (no extra cycle of lag, which would
    // otherwise let req_ready or resp_valid linger one cycle too long).
    always_comb begin
        req_ready_d     = (state_d == S_IDLE);
        busy_d          = (state_d != S_IDLE);
        resp_valid_d    = (state_d == S_OUT);
        puf_en_d        = (state_d == S_RUN);
        puf_reset_d     = (state_d == S_IDLE) || (state_d == S_CLR) ||
                          (state_d == S_OUT);
        puf_challenge_d = puf_challenge_q;
        if ((state_d == S_CLR) || (state_d == S_RUN) ||
            (state_d == S_HOLD) || (state_d == S_SAMPLE)) begin
            // 8-bit sum wraps naturally: 0xFF + 1 = 0x00
            puf_challenge_d = base_d + 8'(bit_idx_d);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            bit_idx_q       <= '0;
            base_q          <= '0;
            resp_data_q     <= '0;
            req_ready_q     <= 1'b1;
            resp_valid_q    <= 1'b0;
            busy_q          <= 1'b0;
            puf_en_q        <= 1'b0;
            puf_reset_q     <= 1'b1;
            puf_challenge_q <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            bit_idx_q       <= bit_idx_d;
            base_q          <= base_d;
            resp_data_q     <= resp_data_d;
            req_ready_q     <= req_ready_d;
            resp_valid_q    <= resp_valid_d;
            busy_q          <= busy_d;
            puf_en_q        <= puf_en_d;
            puf_reset_q     <= puf_reset_d;
            puf_challenge_q <= puf_challenge_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_data     = resp_data_q;
    assign busy          = busy_q;
    assign puf_en        = puf_en_q;
    assign puf_reset     = puf_reset_q;
    assign puf_challenge = puf_challenge_q;

endmodule
`default_nettype wire

// File: tb/tb_puf_eval_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_puf_eval_ctrl
//  Description : Self-checking bench for puf_eval_ctrl. A lookup-table PUF
//                model answers the DUT's challenges; expected responses and
//                per-cycle pin activity are derived from the phase lengths.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_puf_eval_ctrl;

    localparam int RB      = 4;
    localparam int WIN     = 8;
    localparam int SET     = 2;
    localparam int CLRC    = 2;
    localparam int PER_BIT = CLRC + WIN + SET + 1;
    localparam int LAT     = RB * PER_BIT + 1;
    localparam int TIMEOUT = 300;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [7:0]    req_challenge;
    logic          resp_valid;
    logic          resp_ready;
    logic [RB-1:0] resp_data;
    logic          busy;
    logic          puf_en;
    logic          puf_reset;
    logic [7:0]    puf_challenge;
    logic          puf_out;

    bit   f_tab [256];
    int   n_chk  = 0;
    int   n_fail = 0;

    logic       q_en  [$];
    logic       q_rst [$];
    logic [7:0] q_ch  [$];

    always #5 clk = ~clk;

    assign puf_out = f_tab[puf_challenge];

    puf_eval_ctrl #(
        .RESP_BITS    (RB),
        .WIN_CYCLES   (WIN),
        .SETTLE_CYCLES(SET),
        .CLR_CYCLES   (CLRC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_challenge(req_challenge),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .busy         (busy),
        .puf_en       (puf_en),
        .puf_reset    (puf_reset),
        .puf_challenge(puf_challenge),
        .puf_out      (puf_out)
    );

    function automatic logic [RB-1:0] model_resp(input logic [7:0] base);
        logic [RB-1:0] r;
        r = '0;
        for (int k = 0; k < RB; k++) r[k] = f_tab[8'(base + k)];
        return r;
    endfunction

    task automatic clear_tab();
        for (int i = 0; i < 256; i++) f_tab[i] = 1'b0;
    endtask

    task automatic rand_tab();
        for (int i = 0; i < 256; i++) f_tab[i] = 1'($urandom_range(0, 1));
    endtask

    // Issues one request and returns at the negedge where resp_valid is
    // first seen. lat counts negedges from the accept cycle; the pin trace
    // of every cycle in between is stored in the queues.
    task automatic run_req(input logic [7:0] base, output int wait_cyc, output int lat);
        q_en.delete();
        q_rst.delete();
        q_ch.delete();
        @(negedge clk);
        req_valid     = 1'b1;
        req_challenge = base;
        wait_cyc      = 0;
        while (!req_ready && wait_cyc < TIMEOUT) begin
            @(negedge clk);
            wait_cyc++;
        end
        lat = 0;
        do begin
            @(negedge clk);
            if (lat == 0) begin
                req_valid     = 1'b0;
                req_challenge = 8'($urandom);
            end
            lat++;
            if (!resp_valid) begin
                q_en.push_back(puf_en);
                q_rst.push_back(puf_reset);
                q_ch.push_back(puf_challenge);
            end
        end while (!resp_valid && lat < TIMEOUT);
    endtask

    task automatic ack_resp();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; req_challenge = 8'h00;
        clear_tab();
        repeat (3) @(negedge clk);
        n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        n_chk++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        n_chk++; if (resp_data !== '0) begin n_fail++; $display("FAIL reset_resp_data: got %h want 0", resp_data); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_chk++; if (puf_en !== 1'b0) begin n_fail++; $display("FAIL reset_puf_en: got %b want 0", puf_en); end
        n_chk++; if (puf_reset !== 1'b1) begin n_fail++; $display("FAIL reset_puf_reset: got %b want 1", puf_reset); end
        n_chk++; if (puf_challenge !== 8'h00) begin n_fail++; $display("FAIL reset_puf_challenge: got %h want 00", puf_challenge); end
        reset = 1'b0;
        @(negedge clk);
        n_chk++; if (busy !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL idle_after_reset: busy=%b ready=%b want 0/1", busy, req_ready); end
    endtask

    task automatic test_basic();
        int w, lat;
        clear_tab();
        f_tab[8'h11] = 1'b1;
        f_tab[8'h13] = 1'b1;
        run_req(8'h10, w, lat);
        n_chk++; if (w !== 0) begin n_fail++; $display("FAIL basic_accept_wait: got %0d want 0", w); end
        n_chk++; if (lat !== LAT) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", lat, LAT); end
        n_chk++; if (resp_data !== 4'b1010) begin n_fail++; $display("FAIL basic_resp: got %b want 1010", resp_data); end
        n_chk++; if (busy !== 1'b1 || req_ready !== 1'b0) begin n_fail++; $display("FAIL basic_out_flags: busy=%b ready=%b want 1/0", busy, req_ready); end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        n_chk++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_handshake: valid=%b ready=%b busy=%b want 0/1/0", resp_valid, req_ready, busy);
        end
        n_chk++; if (resp_data !== 4'b1010) begin n_fail++; $display("FAIL basic_resp_hold: got %b want 1010", resp_data); end
    endtask

    task automatic test_phase_timing(input logic [7:0] base, input string tag);
        int w, lat, bad_en, bad_rst, bad_ch, both;
        run_req(base, w, lat);
        n_chk++; if (q_en.size() !== LAT - 1) begin n_fail++; $display("FAIL %s_trace_len: got %0d want %0d", tag, q_en.size(), LAT - 1); end
        bad_en = 0; bad_rst = 0; bad_ch = 0; both = 0;
        for (int j = 0; j < q_en.size(); j++) begin
            int         b, p;
            logic       e_rst, e_en;
            logic [7:0] e_ch;
            b     = j / PER_BIT;
            p     = j % PER_BIT;
            e_rst = (p < CLRC);
            e_en  = (p >= CLRC) && (p < CLRC + WIN);
            e_ch  = 8'(base + b);
            if (q_en[j] !== e_en) bad_en++;
            if (q_rst[j] !== e_rst) bad_rst++;
            if (q_ch[j] !== e_ch) bad_ch++;
            if (q_en[j] === 1'b1 && q_rst[j] === 1'b1) both++;
        end
        n_chk++; if (bad_en !== 0) begin n_fail++; $display("FAIL %s_puf_en_pattern: %0d bad cycles want 0", tag, bad_en); end
        n_chk++; if (bad_rst !== 0) begin n_fail++; $display("FAIL %s_puf_reset_pattern: %0d bad cycles want 0", tag, bad_rst); end
        n_chk++; if (bad_ch !== 0) begin n_fail++; $display("FAIL %s_challenge_seq: %0d bad cycles want 0", tag, bad_ch); end
        n_chk++; if (both !== 0) begin n_fail++; $display("FAIL %s_en_reset_overlap: %0d cycles want 0", tag, both); end
        n_chk++; if (resp_data !== model_resp(base)) begin n_fail++; $display("FAIL %s_resp: got %b want %b", tag, resp_data, model_resp(base)); end
        ack_resp();
    endtask

    task automatic test_wrap();
        clear_tab();
        f_tab[8'h00] = 1'b1;
        n_chk++; if (model_resp(8'hFE) !== 4'b0100) begin n_fail++; $display("FAIL wrap_model: got %b want 0100", model_resp(8'hFE)); end
        test_phase_timing(8'hFE, "wrap");
    endtask

    task automatic test_backpressure();
        int            w, lat, bad;
        logic [7:0]    base;
        logic [RB-1:0] exp_r;
        rand_tab();
        base  = 8'($urandom);
        exp_r = model_resp(base);
        run_req(base, w, lat);
        n_chk++; if (lat !== LAT) begin n_fail++; $display("FAIL bp_latency: got %0d want %0d", lat, LAT); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            req_valid     = 1'($urandom_range(0, 1));
            req_challenge = 8'($urandom);
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_data !== exp_r || req_ready !== 1'b0) bad++;
        end
        req_valid = 1'b0;
        n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL bp_hold: %0d bad cycles want 0", bad); end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        n_chk++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: valid=%b ready=%b want 0/1", resp_valid, req_ready); end
        @(negedge clk);
        n_chk++; if (busy !== 1'b0 || resp_data !== exp_r) begin n_fail++; $display("FAIL bp_idle: busy=%b data=%b want 0/%b", busy, resp_data, exp_r); end
    endtask

    task automatic test_reset_mid();
        int         w, lat, seen;
        logic [7:0] base;
        rand_tab();
        base = 8'($urandom);
        @(negedge clk);
        req_valid = 1'b1; req_challenge = base;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2 * PER_BIT + CLRC + 3) @(negedge clk);
        n_chk++; if (puf_en !== 1'b1 || puf_challenge !== 8'(base + 2)) begin
            n_fail++; $display("FAIL mid_in_run_bit2: en=%b ch=%h want 1/%h", puf_en, puf_challenge, 8'(base + 2));
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_chk++; if (puf_en !== 1'b0 || puf_reset !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0 ||
                     resp_data !== '0 || req_ready !== 1'b1 || puf_challenge !== 8'h00) begin
            n_fail++; $display("FAIL mid_reset_outputs: en=%b rst=%b busy=%b valid=%b data=%b ready=%b ch=%h",
                               puf_en, puf_reset, busy, resp_valid, resp_data, req_ready, puf_challenge);
        end
        seen = 0;
        repeat (LAT + 5) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || busy !== 1'b0) seen++;
        end
        n_chk++; if (seen !== 0) begin n_fail++; $display("FAIL mid_no_resume: %0d active cycles want 0", seen); end
        base = 8'($urandom);
        run_req(base, w, lat);
        n_chk++; if (lat !== LAT || resp_data !== model_resp(base)) begin
            n_fail++; $display("FAIL mid_after_req: lat=%0d data=%b want %0d/%b", lat, resp_data, LAT, model_resp(base));
        end
        ack_resp();
    endtask

    task automatic test_back_to_back();
        int            w1, l1, w2, l2;
        logic [7:0]    b1, b2;
        logic [RB-1:0] r1, r2;
        rand_tab();
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        resp_ready = 1'b1;
        run_req(b1, w1, l1);
        r1 = resp_data;
        run_req(b2, w2, l2);
        r2 = resp_data;
        n_chk++; if (w1 !== 0 || l1 !== LAT) begin n_fail++; $display("FAIL b2b_first_timing: wait=%0d lat=%0d want 0/%0d", w1, l1, LAT); end
        n_chk++; if (r1 !== model_resp(b1)) begin n_fail++; $display("FAIL b2b_first_resp: got %b want %b", r1, model_resp(b1)); end
        n_chk++; if (w2 !== 0 || l2 !== LAT) begin n_fail++; $display("FAIL b2b_second_timing: wait=%0d lat=%0d want 0/%0d", w2, l2, LAT); end
        n_chk++; if (r2 !== model_resp(b2)) begin n_fail++; $display("FAIL b2b_second_resp: got %b want %b", r2, model_resp(b2)); end
        @(negedge clk);
        resp_ready = 1'b0;
        n_chk++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_final_idle: ready=%b valid=%b want 1/0", req_ready, resp_valid); end
    endtask

    task automatic test_random();
        int         w, lat;
        logic [7:0] base;
        for (int n = 0; n < 6; n++) begin
            rand_tab();
            base = 8'($urandom);
            run_req(base, w, lat);
            n_chk++; if (lat !== LAT) begin n_fail++; $display("FAIL rand%0d_latency: got %0d want %0d", n, lat, LAT); end
            n_chk++; if (resp_data !== model_resp(base)) begin n_fail++; $display("FAIL rand%0d_resp: base %h got %b want %b", n, base, resp_data, model_resp(base)); end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            ack_resp();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        clear_tab();
        f_tab[8'h11] = 1'b1;
        f_tab[8'h13] = 1'b1;
        test_phase_timing(8'h10, "phase");
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
